// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front-end conditioning for the calculator's four push-buttons. Each raw
// button is brought into the CLK domain through a two-flop synchroniser, then
// debounced by a per-button stability counter. The block outputs the clean
// debounced level and a one-cycle pulse on every accepted press.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles the synchronised input must differ from
//                    the stable state before the new value is accepted (>= 2)
//   CNT_W            stability counter width
//
// Ports:
//   CLK                     system clock, rising edge
//   RESET                   synchronous, active-high reset
//   ButtonUp_unfiltered     raw Up button (asynchronous, bouncing)
//   ButtonDown_unfiltered   raw Down button (asynchronous, bouncing)
//   ButtonLeft_unfiltered   raw Left button (asynchronous, bouncing)
//   ButtonRight_unfiltered  raw Right button (asynchronous, bouncing)
//   BTN_LEVEL[3:0]          debounced state {Right, Left, Down, Up}
//   BTN_PRESS[3:0]          one-cycle pulse per accepted 0->1, same bit order
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ButtonUp_unfiltered,
    input  logic       ButtonDown_unfiltered,
    input  logic       ButtonLeft_unfiltered,
    input  logic       ButtonRight_unfiltered,
    output logic [3:0] BTN_LEVEL,
    output logic [3:0] BTN_PRESS
);

    localparam int unsigned NUM_BTN = 4;

    // Terminal count: the mismatch seen while the counter sits here is the
    // last one needed, so the new value is accepted on that edge.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_nxt;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] press_nxt;
    logic [CNT_W-1:0]   cnt     [NUM_BTN];
    logic [CNT_W-1:0]   cnt_nxt [NUM_BTN];

    assign raw = {ButtonRight_unfiltered, ButtonLeft_unfiltered,
                  ButtonDown_unfiltered,  ButtonUp_unfiltered};

    // Two-flop synchroniser; only sync2 is used downstream.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce decision. Any cycle where sync2 agrees with the
    // stable state clears the counter, so a bounce restarts qualification.
    always_comb begin
        level_nxt = level;
        press_nxt = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = sync2[i];
                    // Only a rising acceptance produces a pulse.
                    press_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            level <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level <= level_nxt;
            press <= press_nxt;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign BTN_LEVEL = level;
    assign BTN_PRESS = press;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int D = 4;

    logic       CLK;
    logic       RESET;
    logic [3:0] raw;
    logic [3:0] BTN_LEVEL;
    logic [3:0] BTN_PRESS;

    int n_vec;
    int n_err;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .ButtonUp_unfiltered    (raw[0]),
        .ButtonDown_unfiltered  (raw[1]),
        .ButtonLeft_unfiltered  (raw[2]),
        .ButtonRight_unfiltered (raw[3]),
        .BTN_LEVEL              (BTN_LEVEL),
        .BTN_PRESS              (BTN_PRESS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: a two-sample delay line for synchronisation, then a
    // window of the last D synchronised samples since reset. A channel flips
    // when all D samples in the window disagree with its stable state.
    // ------------------------------------------------------------------
    logic [3:0] m_s1, m_s2, m_level, m_press, m_nl;
    logic [3:0] m_hist[$];
    bit         m_all;
    bit         model_valid = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_s1 = '0;
            m_s2 = '0;
            m_level = '0;
            m_press = '0;
            m_hist.delete();
            model_valid = 1'b1;
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            m_nl = m_level;
            for (int ch = 0; ch < 4; ch++) begin
                if (m_hist.size() == D) begin
                    m_all = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][ch] == m_level[ch]) m_all = 1'b0;
                    if (m_all) m_nl[ch] = ~m_level[ch];
                end
            end
            m_press = m_nl & ~m_level;
            m_level = m_nl;
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (model_valid) begin
            check("model_level", BTN_LEVEL, m_level);
            check("model_press", BTN_PRESS, m_press);
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    int hold [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        RESET = 1'b1;
        raw   = 4'b1111;

        // Reset values with all buttons held
        repeat (3) begin
            tick();
            check("rst_level", BTN_LEVEL, 4'b0000);
            check("rst_press", BTN_PRESS, 4'b0000);
        end
        RESET = 1'b0;
        raw   = 4'b0000;
        repeat (8) tick();

        // Clean press on Up, then release
        raw = 4'b0001;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("press_e4_level", BTN_LEVEL, 4'b0000);
            if (e == 5) begin
                check("press_e5_level", BTN_LEVEL, 4'b0001);
                check("press_e5_pulse", BTN_PRESS, 4'b0001);
            end
            if (e == 6) begin
                check("press_e6_level", BTN_LEVEL, 4'b0001);
                check("press_e6_pulse", BTN_PRESS, 4'b0000);
            end
        end
        repeat (4) tick();
        raw = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("rel_e4_level", BTN_LEVEL, 4'b0001);
            if (e == 5) check("rel_e5_level", BTN_LEVEL, 4'b0000);
            check("rel_pulse", BTN_PRESS, 4'b0000);
        end
        repeat (4) tick();

        // Bounce on Left: 1,0,1,0 every 2 cycles, then hold 1
        for (int p = 0; p < 4; p++) begin
            raw = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            repeat (2) begin
                tick();
                check("bounce_level", BTN_LEVEL, 4'b0000);
            end
        end
        raw = 4'b0100;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("bounce_e4_level", BTN_LEVEL, 4'b0000);
            if (e == 5) begin
                check("bounce_e5_level", BTN_LEVEL, 4'b0100);
                check("bounce_e5_pulse", BTN_PRESS, 4'b0100);
            end
            if (e == 6) check("bounce_e6_pulse", BTN_PRESS, 4'b0000);
        end
        raw = 4'b0000;
        repeat (10) tick();

        // Short glitch on Down (3 cycles)
        raw = 4'b0010;
        repeat (3) tick();
        raw = 4'b0000;
        repeat (10) begin
            tick();
            check("glitch_level", BTN_LEVEL, 4'b0000);
            check("glitch_pulse", BTN_PRESS, 4'b0000);
        end

        // Simultaneous press on all four buttons
        raw = 4'b1111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("simul_e4_pulse", BTN_PRESS, 4'b0000);
            if (e == 5) check("simul_e5_pulse", BTN_PRESS, 4'b1111);
            if (e == 6) begin
                check("simul_e6_level", BTN_LEVEL, 4'b1111);
                check("simul_e6_pulse", BTN_PRESS, 4'b0000);
            end
        end
        raw = 4'b0000;
        repeat (10) tick();

        // Reset while Right is mid-count (counter at 2 after edge 3)
        raw = 4'b1000;
        for (int e = 0; e <= 3; e++) tick();
        RESET = 1'b1;
        tick();
        check("midrst_level", BTN_LEVEL, 4'b0000);
        RESET = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) check("midrst_e4_level", BTN_LEVEL, 4'b0000);
            if (e == 5) begin
                check("midrst_e5_level", BTN_LEVEL, 4'b1000);
                check("midrst_e5_pulse", BTN_PRESS, 4'b1000);
            end
            if (e == 6) check("midrst_e6_pulse", BTN_PRESS, 4'b0000);
        end
        raw = 4'b0000;
        repeat (10) tick();

        // Randomised bouncing with mixed short and long holds, rare resets
        for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (hold[ch] == 0) begin
                    raw[ch] = ~raw[ch];
                    if ($urandom_range(0, 3) == 0)
                        hold[ch] = int'($urandom_range(5, 14));
                    else
                        hold[ch] = int'($urandom_range(1, 5));
                end else begin
                    hold[ch]--;
                end
            end
            RESET = ($urandom_range(0, 299) == 0);
            tick();
        end
        RESET = 1'b0;
        raw   = 4'b0000;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
